// File: rtl/ssi_pkg.sv
// ssi_pkg: shared glyph table, scan state encoding and pin polarity helper
package ssi_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic [31:0] pol_mask(input bit act_low);
        return act_low ? '1 : '0;
    endfunction
endpackage

// File: rtl/ssi_hex_decode.sv
// ssi_hex_decode: nibble to active-high {g,f,e,d,c,b,a} segments
module ssi_hex_decode
    import ssi_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = GLYPHS[nibble];
endmodule

// File: rtl/ssi_scan_driver.sv
// ssi_scan_driver: multiplexed seven-segment scanner with blanking, LZ suppression, dp, PWM and frame snapshots
module ssi_scan_driver
    import ssi_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int PWM_W        = 4,
    parameter bit DIG_ACT_LOW  = 1'b1,
    parameter bit SEG_ACT_LOW  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic [4*DIGITS-1:0]   i_digits,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_lz_suppress,
    input  logic [PWM_W-1:0]      i_brightness,
    output logic [DIGITS-1:0]     o_dig_sel,
    output logic [6:0]            o_segments,
    output logic                  o_dp,
    output logic                  o_frame_tick
);
    localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(DWELL_CYCLES);
    localparam logic [DIGITS-1:0] DIG_OFF = DIGITS'(pol_mask(DIG_ACT_LOW));
    localparam logic [6:0] SEG_OFF = 7'(pol_mask(SEG_ACT_LOW));

    if (DWELL_CYCLES <= BLANK_CYCLES || BLANK_CYCLES < 1 || DIGITS < 1) begin : g_bad_params
        $error("ssi_scan_driver: need DWELL_CYCLES > BLANK_CYCLES >= 1 and DIGITS >= 1");
    end

    state_e state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [PWM_W-1:0] phase_q, bright_snap;
    logic [4*DIGITS-1:0] dig_snap;
    logic [DIGITS-1:0] dp_snap, lz_mask, sel_oh;
    logic lz_snap, lz_run, wrap, running, take, seg_on, sel_on;
    logic [6:0] glyph;

    ssi_hex_decode u_dec (.nibble(dig_snap[4*slot_q +: 4]), .seg(glyph));

    always_comb begin
        wrap    = tmr_q == TW'(DWELL_CYCLES - 1);
        running = i_enable && state_q != IDLE;
        tmr_d   = running ? (wrap ? '0 : tmr_q + 1'b1) : '0;
        slot_d  = !running ? '0 : !wrap ? slot_q : slot_q == SW'(DIGITS - 1) ? '0 : slot_q + 1'b1;
        state_d = !i_enable ? IDLE : tmr_d < TW'(BLANK_CYCLES) ? BLANK : SHOW;
        take    = state_q == BLANK && slot_q == '0 && tmr_q == '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= BLANK;
            tmr_q   <= '0;
            slot_q  <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            slot_q  <= slot_d;
            phase_q <= phase_q == PWM_W'(2**PWM_W - 2) ? '0 : phase_q + 1'b1;
        end
    end

    // Inputs are sampled once per frame so a value never tears across slots
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dig_snap    <= '0;
            dp_snap     <= '0;
            lz_snap     <= 1'b0;
            bright_snap <= '0;
        end else if (take) begin
            dig_snap    <= i_digits;
            dp_snap     <= i_dp;
            lz_snap     <= i_lz_suppress;
            bright_snap <= i_brightness;
        end
    end

    always_comb begin
        lz_mask = '0;
        lz_run  = lz_snap;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run && dig_snap[4*i +: 4] == 4'd0 && !dp_snap[i];
            lz_mask[i] = lz_run && i != 0;
        end
        seg_on = state_q == SHOW && !lz_mask[slot_q];
        sel_on = seg_on && phase_q < bright_snap;
        sel_oh = sel_on ? DIGITS'(1) << slot_q : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_dig_sel    <= DIG_OFF;
            o_segments   <= SEG_OFF;
            o_dp         <= SEG_OFF[0];
            o_frame_tick <= 1'b0;
        end else begin
            o_dig_sel    <= sel_oh ^ DIG_OFF;
            o_segments   <= (seg_on ? glyph : 7'h00) ^ SEG_OFF;
            o_dp         <= (seg_on && dp_snap[slot_q]) ^ SEG_OFF[0];
            o_frame_tick <= running && wrap && slot_q == SW'(DIGITS - 1);
        end
    end
endmodule
